// File: rtl/hex_digest_sender.sv
// Streams a finished digest as ASCII hex (MSB nibble first), optionally followed by CR LF,
// into an async_transmitter through its start/data/busy handshake.
module hex_digest_sender #(
   parameter int DIGEST_BITS = 128,
   parameter bit UPPERCASE   = 1'b0,
   parameter bit APPEND_CRLF = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   digest_valid,
   input  logic [DIGEST_BITS-1:0] digest,
   output logic                   digest_ready,
   output logic                   tx_start,
   output logic [7:0]             tx_data,
   input  logic                   tx_busy,
   output logic                   busy,
   output logic                   done,
   output logic [2:0]             dbgState
);

   localparam int NDIGITS = DIGEST_BITS / 4;
   localparam int NCHARS  = NDIGITS + (APPEND_CRLF ? 2 : 0);
   // One spare count value so the hex-digit boundary is representable even without CR LF.
   localparam int CW      = $clog2(NCHARS + 1);
   localparam logic [CW-1:0] DIGIT_END = CW'(NDIGITS);
   localparam logic [CW-1:0] LAST_IDX  = CW'(NCHARS - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      REQ   = 3'd2,
      ACK   = 3'd3,
      DRAIN = 3'd4
   } stateT;

   // Handshake: a digest is taken on any edge where digest_valid && digest_ready.
   // Toward the transmitter, tx_start is a one-cycle pulse raised only when tx_busy is low;
   // the byte is then considered sent once tx_busy has risen and fallen again.

   stateT                  state;
   logic [DIGEST_BITS-1:0] sr;
   logic [CW-1:0]          cnt;
   logic [3:0]             nibble;
   logic [7:0]             curChar;

   assign nibble       = sr[DIGEST_BITS-1 -: 4];
   assign digest_ready = (state == IDLE);
   assign busy         = ~digest_ready;
   assign dbgState     = state;

   // 0x37 / 0x57 are 'A' / 'a' minus ten, so nibble values 10..15 land on the letters.
   always_comb begin
      curChar = 8'h0A;
      if (cnt < DIGIT_END) begin
         if (nibble <= 4'd9)
            curChar = 8'h30 + {4'h0, nibble};
         else
            curChar = (UPPERCASE ? 8'h37 : 8'h57) + {4'h0, nibble};
      end else if (cnt == DIGIT_END) begin
         curChar = 8'h0D;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         sr       <= '0;
         cnt      <= '0;
         tx_start <= 1'b0;
         tx_data  <= 8'h00;
         done     <= 1'b0;
      end else begin
         done     <= 1'b0;
         tx_start <= 1'b0;
         case (state)
            IDLE: begin
               if (digest_valid) begin
                  sr    <= digest;
                  cnt   <= '0;
                  state <= LOAD;
               end
            end
            LOAD: begin
               if (!tx_busy) begin
                  tx_data  <= curChar;
                  tx_start <= 1'b1;
                  state    <= REQ;
               end
            end
            REQ: begin
               state <= ACK;
            end
            // The transmitter raises busy one cycle after it sees the start pulse.
            ACK: begin
               if (tx_busy)
                  state <= DRAIN;
            end
            DRAIN: begin
               if (!tx_busy) begin
                  if (cnt == LAST_IDX) begin
                     done  <= 1'b1;
                     state <= IDLE;
                  end else begin
                     cnt <= cnt + 1'b1;
                     if (cnt < DIGIT_END)
                        sr <= sr << 4;
                     state <= LOAD;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
